// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared constants, FSM state type and op legality check for alu_seq_ctrl
//
// Purpose : ALU function-code encodings (same as the ALU's aluctrl input),
//           the issue-controller state enum, and is_legal_op().
// Ports   : none (package).

package alu_seq_ctrl_pkg;

  localparam int DATA_W  = 64;
  localparam int SHAMT_W = 6;
  localparam int CODE_W  = 4;

  localparam logic [CODE_W-1:0] OP_ADD = 4'b0000;
  localparam logic [CODE_W-1:0] OP_SUB = 4'b0001;
  localparam logic [CODE_W-1:0] OP_AND = 4'b0010;
  localparam logic [CODE_W-1:0] OP_OR  = 4'b0011;
  localparam logic [CODE_W-1:0] OP_XOR = 4'b0100;
  localparam logic [CODE_W-1:0] OP_EQ  = 4'b0110;
  localparam logic [CODE_W-1:0] OP_LT  = 4'b1001;  // unsigned compare
  localparam logic [CODE_W-1:0] OP_SRL = 4'b1100;
  localparam logic [CODE_W-1:0] OP_NE  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Codes outside this set would select the ALU's X default, so they are
  // never allowed onto alu_ctrl.
  function automatic logic is_legal_op(input logic [CODE_W-1:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_EQ, OP_LT, OP_SRL, OP_NE: is_legal_op = 1'b1;
      default:                     is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - request, ALU-side and result channel bundle for alu_seq_ctrl
//
// Purpose : groups every non-clock/reset signal of the issue controller.
// Ports   : op_valid/op_ready/op_code/op_a/op_b/op_shamt/op_tag  request channel
//           alu_A/alu_B/alu_shamt/alu_ctrl                       to the ALU
//           alu_Z                                                from the ALU (registered)
//           res_valid/res_ready/res_data/res_tag/res_err         result channel
//           op_count                                             completed legal ops
// Modports: master = dispatch/ALU/consumer side, slave = controller side.

interface alu_seq_ctrl_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
);
  import alu_seq_ctrl_pkg::*;

  logic                op_valid;
  logic                op_ready;
  logic [CODE_W-1:0]   op_code;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [SHAMT_W-1:0]  op_shamt;
  logic [TAG_W-1:0]    op_tag;

  logic [DATA_W-1:0]   alu_A;
  logic [DATA_W-1:0]   alu_B;
  logic [SHAMT_W-1:0]  alu_shamt;
  logic [CODE_W-1:0]   alu_ctrl;
  logic [DATA_W-1:0]   alu_Z;

  logic                res_valid;
  logic                res_ready;
  logic [DATA_W-1:0]   res_data;
  logic [TAG_W-1:0]    res_tag;
  logic                res_err;

  logic [CNT_W-1:0]    op_count;

  modport master (
    output op_valid, op_code, op_a, op_b, op_shamt, op_tag,
    input  op_ready,
    input  alu_A, alu_B, alu_shamt, alu_ctrl,
    output alu_Z,
    input  res_valid, res_data, res_tag, res_err,
    output res_ready,
    input  op_count
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, op_shamt, op_tag,
    output op_ready,
    output alu_A, alu_B, alu_shamt, alu_ctrl,
    input  alu_Z,
    output res_valid, res_data, res_tag, res_err,
    input  res_ready,
    output op_count
  );

endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - issue-side controller for the registered 64-bit ALU
//
// Purpose : accepts one op per handshake, holds operands on the ALU inputs
//           while the ALU's one-cycle registered latency elapses, captures
//           alu_Z and returns it tagged on the result channel. Illegal codes
//           bypass the ALU and return res_err=1 with res_data=0.
// Ports   : CLK  system clock, rising edge
//           RST  asynchronous active-high reset
//           bus  alu_seq_ctrl_if.slave (request, ALU, result, op_count)

module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  alu_seq_ctrl_if.slave     bus
);

  state_e              state_q,     state_d;
  logic [DATA_W-1:0]   alu_a_q,     alu_a_d;
  logic [DATA_W-1:0]   alu_b_q,     alu_b_d;
  logic [SHAMT_W-1:0]  alu_shamt_q, alu_shamt_d;
  logic [CODE_W-1:0]   alu_ctrl_q,  alu_ctrl_d;
  logic [DATA_W-1:0]   res_data_q,  res_data_d;
  logic [TAG_W-1:0]    res_tag_q,   res_tag_d;
  logic                res_err_q,   res_err_d;
  logic [CNT_W-1:0]    op_count_q,  op_count_d;

  logic op_ready;
  logic res_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_shamt_q <= '0;
      alu_ctrl_q  <= OP_ADD;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_shamt_q <= alu_shamt_d;
      alu_ctrl_q  <= alu_ctrl_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
      op_count_q  <= op_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_shamt_d = alu_shamt_q;
    alu_ctrl_d  = alu_ctrl_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    op_count_d  = op_count_q;
    op_ready    = 1'b0;
    res_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (bus.op_valid) begin
          res_tag_d = bus.op_tag;
          if (is_legal_op(bus.op_code)) begin
            alu_a_d     = bus.op_a;
            alu_b_d     = bus.op_b;
            alu_shamt_d = bus.op_shamt;
            alu_ctrl_d  = bus.op_code;
            state_d     = EXEC;
          end else begin
            // ALU inputs keep their last legal values so alu_ctrl never
            // carries an unsupported code.
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = RESP;
          end
        end
      end
      // ALU registers its result at the end of this cycle.
      EXEC: state_d = CAPT;
      // CAPT is only reachable through EXEC, so alu_Z is always fresh here
      // even though the ALU's own register is not reset.
      CAPT: begin
        res_data_d = bus.alu_Z;
        res_err_d  = 1'b0;
        state_d    = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = IDLE;
          if (!res_err_q) begin
            op_count_d = op_count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.op_ready  = op_ready;
  assign bus.alu_A     = alu_a_q;
  assign bus.alu_B     = alu_b_q;
  assign bus.alu_shamt = alu_shamt_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_err   = res_err_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl paired with a registered ALU model

module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_seq_ctrl_if #(.TAG_W(4), .CNT_W(32)) bus ();

  alu_seq_ctrl #(.TAG_W(4), .CNT_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Registered ALU: Z follows the inputs one clock later, never reset.
  function automatic logic [63:0] alu_eval(input logic [3:0] c, input logic [63:0] a,
                                           input logic [63:0] b, input logic [5:0] sh);
    case (c)
      4'b0000: alu_eval = a + b;
      4'b0001: alu_eval = a - b;
      4'b0010: alu_eval = a & b;
      4'b0011: alu_eval = a | b;
      4'b0100: alu_eval = a ^ b;
      4'b0110: alu_eval = (a == b) ? 64'd1 : 64'd0;
      4'b1001: alu_eval = (a < b) ? 64'd1 : 64'd0;
      4'b1100: alu_eval = a >> sh;
      4'b1101: alu_eval = (a != b) ? 64'd1 : 64'd0;
      default: alu_eval = 'x;
    endcase
  endfunction

  logic [63:0] alu_z_r;
  always @(posedge CLK) alu_z_r <= alu_eval(bus.alu_ctrl, bus.alu_A, bus.alu_B, bus.alu_shamt);
  assign bus.alu_Z = alu_z_r;

  // Bit n set = code n is legal (0,1,2,3,4,6,9,12,13).
  logic [15:0] legal_mask = 16'b0011_0010_0101_1111;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_count;
  logic [63:0] last_a, last_b;
  logic [5:0]  last_sh;
  logic [3:0]  last_ctrl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    exp_count = '0;
    last_a = '0; last_b = '0; last_sh = '0; last_ctrl = 4'b0000;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_op_ready"},  bus.op_ready,  1);
    check({pfx, "_res_valid"}, bus.res_valid, 0);
    check({pfx, "_res_err"},   bus.res_err,   0);
    check({pfx, "_res_data"},  bus.res_data,  0);
    check({pfx, "_res_tag"},   bus.res_tag,   0);
    check({pfx, "_alu_A"},     bus.alu_A,     0);
    check({pfx, "_alu_B"},     bus.alu_B,     0);
    check({pfx, "_alu_shamt"}, bus.alu_shamt, 0);
    check({pfx, "_alu_ctrl"},  bus.alu_ctrl,  0);
    check({pfx, "_op_count"},  bus.op_count,  0);
  endtask

  // Issues one op from IDLE, stalls the result for 'stall' cycles, retires it.
  // With keep=1 a second request (ADD 0x11+0x22, tag 5) is held on the
  // request channel from the accept edge on, and must not be taken early.
  task automatic run_op(input logic [3:0] code, input logic [63:0] a, input logic [63:0] b,
                        input logic [5:0] sh, input logic [3:0] tag,
                        input logic [63:0] exp_d, input logic exp_e,
                        input int stall, input bit keep);
    int lat;
    check("pre_op_ready", bus.op_ready, 1);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_a = a; bus.op_b = b;
    bus.op_shamt = sh; bus.op_tag = tag;
    bus.res_ready = (stall == 0);
    @(posedge CLK); #1;
    if (keep) begin
      bus.op_code = OP_ADD; bus.op_a = 64'h11; bus.op_b = 64'h22;
      bus.op_shamt = 6'd0; bus.op_tag = 4'h5;
    end else begin
      bus.op_valid = 1'b0;
      bus.op_code = 4'($urandom); bus.op_a = {$urandom, $urandom}; bus.op_b = {$urandom, $urandom};
      bus.op_shamt = 6'($urandom); bus.op_tag = 4'($urandom);
    end
    if (!exp_e) begin
      last_a = a; last_b = b; last_sh = sh; last_ctrl = code;
    end
    lat = 0;
    while (!bus.res_valid && lat < 8) begin
      check("busy_op_ready", bus.op_ready, 0);
      check("hold_alu_A", bus.alu_A, last_a);
      check("hold_alu_ctrl", bus.alu_ctrl, last_ctrl);
      @(posedge CLK); #1;
      lat++;
    end
    check("res_latency", lat, exp_e ? 0 : 2);
    check("hold_alu_B", bus.alu_B, last_b);
    check("hold_alu_shamt", bus.alu_shamt, last_sh);
    check("hold_alu_ctrl_resp", bus.alu_ctrl, last_ctrl);
    for (int s = 0; s < stall; s++) begin
      check("stall_res_valid", bus.res_valid, 1);
      check("stall_res_data", bus.res_data, exp_d);
      check("stall_res_tag", bus.res_tag, tag);
      check("stall_res_err", bus.res_err, exp_e);
      check("stall_op_ready", bus.op_ready, 0);
      check("stall_alu_A", bus.alu_A, last_a);
      @(posedge CLK); #1;
    end
    bus.res_ready = 1'b1;
    check("res_valid", bus.res_valid, 1);
    check("res_data", bus.res_data, exp_d);
    check("res_tag", bus.res_tag, tag);
    check("res_err", bus.res_err, exp_e);
    check("count_before_retire", bus.op_count, exp_count);
    @(posedge CLK); #1;
    bus.res_ready = 1'b0;
    if (!exp_e) exp_count = exp_count + 32'd1;
    check("retired_res_valid", bus.res_valid, 0);
    check("retired_op_ready", bus.op_ready, 1);
    check("retired_op_count", bus.op_count, exp_count);
    check("retired_alu_A", bus.alu_A, last_a);
  endtask

  typedef struct {
    logic [3:0]  code;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  sh;
    logic [3:0]  tag;
    logic [63:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  rc, rt;
    logic [63:0] ra, rb, rd;
    logic [5:0]  rs;
    logic        re;

    vecs[0]  = '{4'b0000, 64'd5, 64'd7, 6'd0, 4'd3, 64'd12, 1'b0};
    vecs[1]  = '{4'b1001, 64'd1, 64'd2, 6'd0, 4'd1, 64'd1, 1'b0};
    vecs[2]  = '{4'b1001, 64'd2, 64'd1, 6'd0, 4'd2, 64'd0, 1'b0};
    vecs[3]  = '{4'b1100, 64'h8000_0000_0000_0000, 64'd0, 6'd63, 4'd4, 64'd1, 1'b0};
    vecs[4]  = '{4'b0111, 64'd123, 64'd456, 6'd7, 4'd9, 64'd0, 1'b1};
    vecs[5]  = '{4'b0001, 64'd10, 64'd3, 6'd0, 4'd6, 64'd7, 1'b0};
    vecs[6]  = '{4'b0010, 64'hF0F0, 64'hFF00, 6'd0, 4'd7, 64'hF000, 1'b0};
    vecs[7]  = '{4'b0011, 64'hF0, 64'h0F, 6'd0, 4'd8, 64'hFF, 1'b0};
    vecs[8]  = '{4'b0100, 64'hFF, 64'h0F, 6'd0, 4'd10, 64'hF0, 1'b0};
    vecs[9]  = '{4'b0110, 64'd5, 64'd5, 6'd0, 4'd11, 64'd1, 1'b0};
    vecs[10] = '{4'b1101, 64'd5, 64'd5, 6'd0, 4'd12, 64'd0, 1'b0};
    vecs[11] = '{4'b1101, 64'd1, 64'd2, 6'd0, 4'd13, 64'd1, 1'b0};
    vecs[12] = '{4'b1111, 64'd9, 64'd9, 6'd1, 4'd14, 64'd0, 1'b1};
    vecs[13] = '{4'b1100, 64'hF0, 64'd0, 6'd4, 4'd15, 64'hF, 1'b0};
    vecs[14] = '{4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 4'd0, 64'd0, 1'b0};

    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_a = '0; bus.op_b = '0;
    bus.op_shamt = '0; bus.op_tag = '0; bus.res_ready = 1'b0;
    reset_model();

    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("rst_held");
    RST = 1'b0;
    @(posedge CLK); #1;
    check_reset_outputs("rst_released");

    // Directed vector table.
    foreach (vecs[i])
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].tag,
             vecs[i].exp_d, vecs[i].exp_e, 0, 1'b0);

    // Long result stall with a competing request held on the input.
    run_op(OP_SUB, 64'd0, 64'd1, 6'd0, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10, 1'b1);
    run_op(OP_ADD, 64'h11, 64'h22, 6'd0, 4'd5, 64'h33, 1'b0, 0, 1'b0);

    // Reset during CAPT discards the op.
    bus.op_valid = 1'b1; bus.op_code = OP_ADD; bus.op_a = 64'd3; bus.op_b = 64'd4;
    bus.op_shamt = 6'd2; bus.op_tag = 4'd7; bus.res_ready = 1'b1;
    @(posedge CLK); #1;
    bus.op_valid = 1'b0;
    @(posedge CLK); #1;
    check("capt_res_valid", bus.res_valid, 0);
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_capt");
    @(posedge CLK); #1;
    RST = 1'b0;
    reset_model();
    for (int c = 0; c < 4; c++) begin
      check("post_rst_no_result", bus.res_valid, 0);
      check("post_rst_op_ready", bus.op_ready, 1);
      @(posedge CLK); #1;
    end
    bus.res_ready = 1'b0;

    // Counter wrap.
    force dut.op_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.op_count_q;
    exp_count = 32'hFFFF_FFFF;
    run_op(OP_OR, 64'h1, 64'h2, 6'd0, 4'd8, 64'h3, 1'b0, 0, 1'b0);
    check("count_wrapped", bus.op_count, 0);

    // Randomized ops against the reference rules.
    for (int i = 0; i < 150; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      rs = 6'($urandom);
      rt = 4'($urandom);
      re = !legal_mask[rc];
      rd = re ? 64'd0 : alu_eval(rc, ra, rb, rs);
      run_op(rc, ra, rb, rs, rt, rd, re, $urandom_range(0, 3), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #1;
        check("gap_res_valid", bus.res_valid, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Issue-side controller for the registered 64-bit ALU. Accepts one operation per valid/ready handshake, drives the ALU's operand and function-code inputs, and waits out the ALU's one-cycle registered latency. It then captures the ALU result and returns it, tagged, on a valid/ready result channel. Unsupported function codes are rejected without issuing to the ALU. Sits between instruction dispatch and the ALU instance in the datapath.

## Interface
Parameters:
- TAG_W, 4, width of the operation tag carried from request to result
- CNT_W, 32, width of the completed-operation counter

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- op_valid  in  1  request present
- op_ready  out  1  controller can accept a request
- op_code  in  4  ALU function code; same encoding as the ALU's aluctrl
- op_a  in  64  operand A
- op_b  in  64  operand B
- op_shamt  in  6  shift amount
- op_tag  in  TAG_W  request tag
- alu_A  out  64  to ALU A
- alu_B  out  64  to ALU B
- alu_shamt  out  6  to ALU shamt
- alu_ctrl  out  4  to ALU aluctrl
- alu_Z  in  64  from ALU Z (registered inside the ALU)
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_data  out  64  result value
- res_tag  out  TAG_W  tag of the originating request
- res_err  out  1  1 = unsupported op_code; res_data is 0
- op_count  out  CNT_W  number of results accepted with res_err=0

## Operation
- Legal codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0110 eq, 1001 lt (unsigned), 1100 srl, 1101 ne. All other codes are illegal.
- FSM states:
  - IDLE: op_ready=1.
    - Accept with a legal code: latch a/b/shamt/code/tag into the alu_* and tag registers, go to EXEC.
    - Accept with an illegal code: set res_err=1, res_data=0, latch tag, go to RESP. alu_* registers are untouched.
  - EXEC: ALU evaluates the held operands; unconditionally go to CAPT.
  - CAPT: alu_Z now holds the result; latch res_data<=alu_Z, res_err<=0, go to RESP.
  - RESP: res_valid=1. On res_ready, go to IDLE. op_count increments by 1 if res_err=0, wrapping modulo 2^CNT_W.
- alu_A/alu_B/alu_shamt/alu_ctrl stay stable from the accept edge through the end of CAPT. Outside that window they retain their last values. alu_ctrl is never driven to an unsupported code, so the ALU's X default is never selected.
- op_ready is low in EXEC, CAPT and RESP. Requests presented then are not accepted and must be held by the source.
- res_data, res_tag and res_err stay stable while res_valid=1 and res_ready=0.

## Timing
- Reset values: op_ready=1 (state IDLE), res_valid=0, res_err=0, res_data=0, res_tag=0, alu_A=0, alu_B=0, alu_shamt=0, alu_ctrl=0000, op_count=0.
- Legal op:
  - accept edge T
  - EXEC during T→T+1; ALU registers Z at T+1
  - CAPT during T+1→T+2; res_data latched at T+2
  - res_valid=1 from T+2
- With res_ready held high, the op is retired at edge T+3 and the next accept can occur at T+4. Peak throughput is one op per 4 cycles.
- Illegal op: accept at T, res_valid=1 from T+1, earliest retire at T+2.
- A res_ready stall holds the FSM in RESP indefinitely; no overflow is possible.
- RST asserted mid-operation (any state) returns the FSM to IDLE immediately and discards the in-flight op with no result. The ALU's own Z register is not reset; a stale alu_Z is ignored because CAPT is only reached via EXEC.

## Structure
- Shared package holds:
  - the ALU function-code constants (names per operation, 4 bits)
  - the FSM state enum (IDLE, EXEC, CAPT, RESP)
  - a function `is_legal_op(code)` returning 1 for the nine legal codes
- The ALU instance stays outside this block. The top level wires alu_* to the ALU's A/B/shamt/aluctrl and Z to alu_Z. No sub-module is needed; the legality check is the package function.

## Test plan
- Bench pairs the controller with the ALU. op_code=0000, a=5, b=7, tag=3, res_ready=1 -> res_valid at T+2 with res_data=12, res_tag=3, res_err=0; op_count=1 after retire.
- op_code=1001 with a=1, b=2 -> res_data=1. Repeat with a=2, b=1 -> res_data=0. op_code=1100, a=0x8000_0000_0000_0000, shamt=63 -> res_data=1.
- op_code=0111 (illegal), tag=9 -> res_valid at T+1, res_err=1, res_data=0, res_tag=9. alu_ctrl holds its previous value; op_count is unchanged.
- Hold res_ready=0 for 10 cycles on a sub result (a=0, b=1 -> res_data=0xFFFF_FFFF_FFFF_FFFF). Output must be stable; op_ready=0 and a second op_valid is not accepted until one cycle after retire.
- Assert RST during CAPT -> next cycle: FSM in IDLE, res_valid=0, op_ready=1, all outputs at reset values; the in-flight op never produces a result.
- Preload op_count=2^32-1 via a sequence (or force), retire one legal op -> op_count=0.
